// File: rtl/adsr_envelope_pkg.sv
// Shared types and defaults for the synth envelope path: state encoding, widths, full-scale level.
package synth_env_pkg;

  localparam int unsigned LEVEL_W_DEF = 16;
  localparam int unsigned RATE_W_DEF  = 27;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned STATE_W     = 3;

  localparam logic [LEVEL_W_DEF-1:0] LEVEL_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/adsr_envelope_if.sv
// Envelope control/result bundle between the register block (master) and the envelope (slave).
interface adsr_envelope_if
  import synth_env_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF,
  parameter int unsigned RATE_W  = RATE_W_DEF
);
  logic                       trigger_i;
  logic [RATE_W-1:0]          attack_i;
  logic [RATE_W-1:0]          decay_i;
  logic [LEVEL_W-1:0]         sustain_i;
  logic [RATE_W-1:0]          fade_i;
  logic [LEVEL_W-1:0]         level_o;
  logic [STATE_W-1:0]         state_o;
  logic                       busy_o;
  logic signed [SAMPLE_W-1:0] sample_i;
  logic                       sample_valid_i;
  logic signed [SAMPLE_W-1:0] sample_o;
  logic                       sample_valid_o;

  modport master (
    output trigger_i, attack_i, decay_i, sustain_i, fade_i, sample_i, sample_valid_i,
    input  level_o, state_o, busy_o, sample_o, sample_valid_o
  );

  modport slave (
    input  trigger_i, attack_i, decay_i, sustain_i, fade_i, sample_i, sample_valid_i,
    output level_o, state_o, busy_o, sample_o, sample_valid_o
  );
endinterface

// File: rtl/adsr_envelope_sample_scaler.sv
// Registered signed sample * envelope-level stage; result floored (arithmetic shift) back to sample width.
module adsr_sample_scaler
  import synth_env_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  input  logic [LEVEL_W-1:0]         level_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sample_valid_o
);
  localparam int unsigned PROD_W = SAMPLE_W + LEVEL_W + 1;

  logic signed [PROD_W-1:0] product;

  // Level is zero-extended so full scale stays positive.
  assign product = PROD_W'(sample_i) * PROD_W'($signed({1'b0, level_i}));

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      sample_valid_o <= sample_valid_i;
      if (sample_valid_i) sample_o <= SAMPLE_W'(product >>> LEVEL_W);
    end
  end
endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with per-state rate prescaler.
// Optional sample scaling stage built only when ADSR_SAMPLE_SCALE_EN is defined.
module adsr_envelope
  import synth_env_pkg::*;
#(
  parameter int unsigned LEVEL_W = LEVEL_W_DEF,
  parameter int unsigned RATE_W  = RATE_W_DEF
) (
  input logic           wb_clk_i,
  input logic           wb_rst_ni,
  adsr_envelope_if.slave env
);
  localparam logic [LEVEL_W-1:0] LVL_FULL = '1;

  env_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [RATE_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0]  rate_sel, period;
  logic               trig_q, busy_q;
  logic               rise, fall, step_due;

  assign rise = env.trigger_i & ~trig_q;
  assign fall = ~env.trigger_i & trig_q;

  // Rates are read live so a shortened period takes effect on the next cycle.
  assign rate_sel = (state_q == ST_ATTACK) ? env.attack_i :
                    (state_q == ST_DECAY)  ? env.decay_i  : env.fade_i;
  assign period   = (rate_sel == '0) ? RATE_W'(1) : rate_sel;
  assign step_due = (cnt_q >= (period - RATE_W'(1)));

  // Next-state/level; trigger edges override every other transition.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    if (rise) begin
      state_d = ST_ATTACK;
      cnt_d   = '0;
    end else if (fall && (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      state_d = ST_RELEASE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          level_d = '0;
          cnt_d   = '0;
        end
        ST_ATTACK: begin
          if (level_q == LVL_FULL) begin
            state_d = ST_DECAY;
            cnt_d   = '0;
          end else if (step_due) begin
            cnt_d   = '0;
            level_d = level_q + LEVEL_W'(1);
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        ST_DECAY: begin
          if (level_q <= env.sustain_i) begin
            state_d = ST_SUSTAIN;
            cnt_d   = '0;
          end else if (step_due) begin
            cnt_d   = '0;
            level_d = level_q - LEVEL_W'(1);
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        ST_SUSTAIN: begin
          level_d = env.sustain_i;
          cnt_d   = '0;
        end
        ST_RELEASE: begin
          if (level_q == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (step_due) begin
            cnt_d   = '0;
            level_d = level_q - LEVEL_W'(1);
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      trig_q  <= env.trigger_i;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign env.level_o = level_q;
  assign env.state_o = state_q;
  assign env.busy_o  = busy_q;

`ifdef ADSR_SAMPLE_SCALE_EN
  adsr_sample_scaler #(.LEVEL_W(LEVEL_W)) u_scaler (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_ni     (wb_rst_ni),
    .sample_i      (env.sample_i),
    .sample_valid_i(env.sample_valid_i),
    .level_i       (level_q),
    .sample_o      (env.sample_o),
    .sample_valid_o(env.sample_valid_o)
  );
`else
  logic unused_sample;
  assign unused_sample      = ^{env.sample_i, env.sample_valid_i};
  assign env.sample_o       = '0;
  assign env.sample_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized notes vs a behavioural model.
module tb_adsr_envelope;
  import synth_env_pkg::*;

  localparam int unsigned LW = 16;
  localparam int unsigned RW = 27;
  localparam int FULL = 65535;
`ifdef ADSR_SAMPLE_SCALE_EN
  localparam int EXP_SCALED = -500;
  localparam int EXP_SVALID = 1;
`else
  localparam int EXP_SCALED = 0;
  localparam int EXP_SVALID = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adsr_envelope_if #(.LEVEL_W(LW), .RATE_W(RW)) env ();
  adsr_envelope #(.LEVEL_W(LW), .RATE_W(RW)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .env      (env)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0..4, level as plain int, cycles-since-last-step counter.
  int m_st = 0, m_lvl = 0, m_cnt = 0, m_so = 0;
  bit m_trig = 1'b0, m_sv = 1'b0;

  task automatic go(input int st);
    m_st  = st;
    m_cnt = 0;
  endtask

  task automatic ramp(input int rate, input int dir);
    int p;
    p = (rate == 0) ? 1 : rate;
    if (m_cnt + 1 >= p) begin
      m_cnt = 0;
      m_lvl = m_lvl + dir;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_lvl = 0; m_cnt = 0; m_trig = 0; m_so = 0; m_sv = 0;
    end else begin
      bit rise, fall;
`ifdef ADSR_SAMPLE_SCALE_EN
      if (env.sample_valid_i)
        m_so = int'((longint'(env.sample_i) * longint'(m_lvl)) >>> LW);
      m_sv = env.sample_valid_i;
`endif
      rise   = env.trigger_i && !m_trig;
      fall   = !env.trigger_i && m_trig;
      m_trig = env.trigger_i;
      if (rise) go(1);
      else if (fall && m_st >= 1 && m_st <= 3) go(4);
      else begin
        case (m_st)
          1: if (m_lvl == FULL) go(2); else ramp(int'(env.attack_i), 1);
          2: if (m_lvl <= int'(env.sustain_i)) go(3); else ramp(int'(env.decay_i), -1);
          3: m_lvl = int'(env.sustain_i);
          4: if (m_lvl == 0) go(0); else ramp(int'(env.fade_i), -1);
          default: m_lvl = 0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("level", int'(env.level_o), m_lvl);
      chk("state", int'(env.state_o), m_st);
      chk("busy", int'(env.busy_o), int'(m_st != 0));
      chk("svalid", int'(env.sample_valid_o), int'(m_sv));
      chk("sample", int'(env.sample_o), m_so);
    end
  end

  task automatic wait_level(input int lvl, input int budget, output int n);
    n = 0;
    while (int'(env.level_o) != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(env.level_o) != lvl) begin
      total++; bad++;
      $display("FAIL wait_level: level %0d never reached %0d", env.level_o, lvl);
    end
  endtask

  task automatic wait_state(input int st, input int budget, output int n);
    n = 0;
    while (int'(env.state_o) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(env.state_o) != st) begin
      total++; bad++;
      $display("FAIL wait_state: state %0d never reached %0d", env.state_o, st);
    end
  endtask

  task automatic rand_cycle();
    env.sample_i       = 16'($urandom);
    env.sample_valid_i = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  initial begin
    int n, hold;
    env.trigger_i = 1'b0; env.attack_i = '0; env.decay_i = '0; env.fade_i = '0;
    env.sustain_i = '0; env.sample_i = '0; env.sample_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_level", int'(env.level_o), 0);
    chk("rst_state", int'(env.state_o), 0);
    chk("rst_busy", int'(env.busy_o), 0);
    chk("rst_svalid", int'(env.sample_valid_o), 0);
    chk("rst_sample", int'(env.sample_o), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Rise: ATTACK after edge k, first step after edge k+1.
    env.attack_i = 1; env.decay_i = 1; env.sustain_i = 16'hFFF0; env.fade_i = 1;
    env.trigger_i = 1'b1;
    @(negedge clk);
    chk("rise_state", int'(env.state_o), 1);
    chk("rise_level", int'(env.level_o), 0);
    @(negedge clk);
    chk("atk_first_step", int'(env.level_o), 1);
    env.attack_i = 0;

    // Scale a sample at level 0x8000.
    wait_level(16'h8000, 70000, n);
    env.sample_i = -16'sd1000; env.sample_valid_i = 1'b1;
    @(negedge clk);
    env.sample_valid_i = 1'b0;
    chk("scale_sample", int'(env.sample_o), EXP_SCALED);
    chk("scale_valid", int'(env.sample_valid_o), EXP_SVALID);
    @(negedge clk);
    chk("scale_valid_drop", int'(env.sample_valid_o), 0);

    // Full scale, then DECAY 15 steps to 0xFFF0, SUSTAIN one cycle later.
    wait_state(2, 70000, n);
    chk("decay_entry_level", int'(env.level_o), 16'hFFFF);
    wait_state(3, 100, n);
    chk("decay_cycles", n, 16);
    chk("sustain_level", int'(env.level_o), 16'hFFF0);

    // Retrigger from RELEASE keeps the level.
    env.trigger_i = 1'b0;
    @(negedge clk);
    chk("fall_state", int'(env.state_o), 4);
    chk("fall_level", int'(env.level_o), 16'hFFF0);
    env.trigger_i = 1'b1;
    @(negedge clk);
    chk("retrig_state", int'(env.state_o), 1);
    chk("retrig_level", int'(env.level_o), 16'hFFF0);

    // Zero-rate decay, then live sustain write to 0 holds SUSTAIN with busy.
    env.decay_i = 0; env.sustain_i = 16'hFF00;
    wait_state(2, 50, n);
    wait_state(3, 400, n);
    chk("decay0_cycles", n, 256);
    chk("sustain_ff00", int'(env.level_o), 16'hFF00);
    env.sustain_i = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("sus0_level", int'(env.level_o), 0);
      chk("sus0_state", int'(env.state_o), 3);
      chk("sus0_busy", int'(env.busy_o), 1);
      @(negedge clk);
    end
    env.sustain_i = 16'hFF00;
    @(negedge clk);
    chk("sus_live", int'(env.level_o), 16'hFF00);

    // Async reset mid-DECAY takes effect without a clock edge.
    env.trigger_i = 1'b0;
    @(negedge clk);
    env.trigger_i = 1'b1;
    wait_state(2, 400, n);
    repeat (100) @(negedge clk);
    chk("pre_reset_state", int'(env.state_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_level", int'(env.level_o), 0);
    chk("areset_state", int'(env.state_o), 0);
    chk("areset_busy", int'(env.busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rise", int'(env.state_o), 1);

    // Early release at 0x0100 with fade 3: 768 cycles to zero, then IDLE.
    env.fade_i = 3;
    wait_level(16'h0100, 400, n);
    env.trigger_i = 1'b0;
    @(negedge clk);
    chk("early_rel_state", int'(env.state_o), 4);
    chk("early_rel_level", int'(env.level_o), 16'h0100);
    wait_level(0, 1000, n);
    chk("fade_cycles", n, 768);
    @(negedge clk);
    chk("idle_state", int'(env.state_o), 0);
    chk("idle_busy", int'(env.busy_o), 0);

    // Randomized notes, gaps, rate changes and samples.
    for (int note = 0; note < 30; note++) begin
      env.attack_i  = RW'($urandom_range(0, 2));
      env.decay_i   = RW'($urandom_range(0, 2));
      env.fade_i    = RW'($urandom_range(0, 2));
      env.sustain_i = LW'($urandom);
      env.trigger_i = 1'b1;
      hold = $urandom_range(1, 150);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 15) == 0) env.attack_i = RW'($urandom_range(0, 3));
        rand_cycle();
      end
      env.trigger_i = 1'b0;
      hold = $urandom_range(0, 150);
      for (int c = 0; c < hold; c++) begin
        if ($urandom_range(0, 15) == 0) env.fade_i = RW'($urandom_range(0, 3));
        rand_cycle();
      end
    end
    env.fade_i = 0;
    env.sample_valid_i = 1'b0;
    wait_state(0, 70000, n);
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
